// File: rtl/hs32_mem_arb.sv
// Two-master round-robin arbiter in front of one HS32 memory-bus slave.
// Registered request/response with per-transaction timeout and error return.
module hs32_mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_dtw,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_dtr,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_dtw,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_dtr,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_dtw,
    input  logic          s_ack,
    input  logic [DW-1:0] s_dtr,
    output logic          grant
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count;
    logic          last;
    logic [DW-1:0] rdata;
    logic          req;
    logic          win;
    logic          expired;

    // Winner selection and next-state decode
    always_comb begin
        req      = m0_stb | m1_stb;
        win      = (m0_stb & m1_stb) ? ~last : m1_stb;
        expired  = (count == CNT_LAST);
        state_nx = state;
        unique case (state)
            IDLE:    if (req) state_nx = ACTIVE;
            ACTIVE:  if (s_ack || expired) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; reset aborts any transaction at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Latched request fields, grant history, timeout count and response pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_we   <= 1'b0;
            s_addr <= '0;
            s_dtw  <= '0;
            grant  <= 1'b0;
            last   <= 1'b1;
            count  <= '0;
            rdata  <= '0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        s_we   <= win ? m1_we   : m0_we;
                        s_addr <= win ? m1_addr : m0_addr;
                        s_dtw  <= win ? m1_dtw  : m0_dtw;
                        grant  <= win;
                        last   <= win;
                        count  <= '0;
                    end
                end
                ACTIVE: begin
                    if (s_ack) begin
                        rdata  <= s_dtr;
                        m0_ack <= ~grant;
                        m1_ack <= grant;
                    end else if (expired) begin
                        rdata  <= '0;
                        m0_err <= ~grant;
                        m1_err <= grant;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_stb  = (state == ACTIVE);
    assign m0_dtr = rdata;
    assign m1_dtr = rdata;

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Directed bench for hs32_mem_arb: single access, contention, wait states,
// timeout, asynchronous reset mid-transaction and input stability.
module tb_hs32_mem_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_stb = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_dtw = '0;
    logic        m0_ack, m0_err;
    logic [31:0] m0_dtr;
    logic        m1_stb = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_dtw = '0;
    logic        m1_ack, m1_err;
    logic [31:0] m1_dtr;
    logic        s_stb, s_we;
    logic [31:0] s_addr, s_dtw;
    logic        s_ack = 1'b0;
    logic [31:0] s_dtr = '0;
    logic        grant;

    int errors = 0;
    int checks = 0;
    int hi;
    logic errseen, ackseen;

    hs32_mem_arb #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dtw(m0_dtw),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_dtr(m0_dtr),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dtw(m1_dtw),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_dtr(m1_dtr),
        .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_dtw(s_dtw),
        .s_ack(s_ack), .s_dtr(s_dtr), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        chk("rst_dtr", m0_dtr, 32'd0);
        reset = 1'b0;

        // single m0 read, slave acks immediately
        s_ack   = 1'b1;
        s_dtr   = 32'hDEAD_BEEF;
        m0_stb  = 1'b1;
        m0_addr = 32'd2;
        tick();
        chk("t1_s_stb", 32'(s_stb), 32'd1);
        chk("t1_s_addr", s_addr, 32'd2);
        chk("t1_grant", 32'(grant), 32'd0);
        chk("t1_ack_early", 32'(m0_ack), 32'd0);
        tick();
        chk("t1_m0_ack", 32'(m0_ack), 32'd1);
        chk("t1_m0_dtr", m0_dtr, 32'hDEAD_BEEF);
        chk("t1_m1_ack", 32'(m1_ack), 32'd0);
        chk("t1_s_stb_resp", 32'(s_stb), 32'd0);
        m0_stb = 1'b0;
        tick();
        chk("t1_ack_pulse", 32'(m0_ack), 32'd0);
        chk("t1_idle_stb", 32'(s_stb), 32'd0);

        // contention from reset: m0, m1, m0
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m0_stb  = 1'b1;
        m1_stb  = 1'b1;
        m0_addr = 32'd10;
        m1_addr = 32'd11;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_s_stb", 32'(s_stb), 32'd1);
            chk("t2_grant", 32'(grant), 32'(k % 2));
            chk("t2_s_addr", s_addr, (k % 2 == 1) ? 32'd11 : 32'd10);
            tick();
            chk("t2_m0_ack", 32'(m0_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_m1_ack", 32'(m1_ack), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k == 2) begin
                m0_stb = 1'b0;
                m1_stb = 1'b0;
            end
            tick();
            chk("t2_idle_stb", 32'(s_stb), 32'd0);
        end

        // m1 write with wait states, master inputs change while active
        s_ack   = 1'b0;
        s_dtr   = 32'h1234_5678;
        m1_stb  = 1'b1;
        m1_we   = 1'b1;
        m1_addr = 32'd3;
        m1_dtw  = 32'd5;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t3_s_stb", 32'(s_stb), 32'd1);
            chk("t3_s_addr", s_addr, 32'd3);
            chk("t3_s_dtw", s_dtw, 32'd5);
            chk("t3_s_we", 32'(s_we), 32'd1);
            chk("t3_grant", 32'(grant), 32'd1);
            chk("t3_no_ack", 32'(m1_ack), 32'd0);
            if (i == 1) begin
                m1_addr = 32'd7;
                m1_dtw  = 32'd9;
            end
            if (i == 4) s_ack = 1'b1;
        end
        tick();
        chk("t3_m1_ack", 32'(m1_ack), 32'd1);
        chk("t3_m1_dtr", m1_dtr, 32'h1234_5678);
        chk("t3_m0_ack", 32'(m0_ack), 32'd0);
        chk("t3_s_stb_resp", 32'(s_stb), 32'd0);
        m1_stb = 1'b0;
        m1_we  = 1'b0;
        s_ack  = 1'b0;
        tick();

        // timeout on m0; address change while active is ignored
        m0_stb  = 1'b1;
        m0_addr = 32'd4;
        hi      = 0;
        errseen = 1'b0;
        ackseen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) m0_addr = 32'd9;
            if (s_stb) begin
                hi++;
                chk("t4_s_addr", s_addr, 32'd4);
            end
            if (m0_ack) ackseen = 1'b1;
            if (m0_err) begin
                errseen = 1'b1;
                break;
            end
        end
        chk("t4_err_seen", 32'(errseen), 32'd1);
        chk("t4_stb_cycles", 32'(hi), 32'd16);
        chk("t4_no_ack", 32'(ackseen | m0_ack), 32'd0);
        chk("t4_dtr_zero", m0_dtr, 32'd0);
        chk("t4_m1_err", 32'(m1_err), 32'd0);
        s_ack = 1'b1;
        tick();
        chk("t4_err_pulse", 32'(m0_err), 32'd0);
        tick();
        chk("t4_new_addr", s_addr, 32'd9);
        tick();
        chk("t4_new_ack", 32'(m0_ack), 32'd1);
        m0_stb = 1'b0;
        s_ack  = 1'b0;
        tick();

        // reset mid-ACTIVE, then m0 wins the first tie
        m0_stb  = 1'b1;
        m1_stb  = 1'b1;
        m0_addr = 32'd20;
        m1_addr = 32'd21;
        tick();
        chk("t5_s_stb", 32'(s_stb), 32'd1);
        chk("t5_grant", 32'(grant), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_async_drop", 32'(s_stb), 32'd0);
        tick();
        chk("t5_no_resp", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        reset = 1'b0;
        tick();
        chk("t5_grant_m0", 32'(grant), 32'd0);
        chk("t5_s_addr", s_addr, 32'd20);
        s_ack = 1'b1;
        tick();
        chk("t5_m0_ack", 32'(m0_ack), 32'd1);
        chk("t5_m1_ack", 32'(m1_ack), 32'd0);
        m0_stb = 1'b0;
        m1_stb = 1'b0;
        s_ack  = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
